// File: rtl/shared_reg_if.sv
// Bus between the requesters and the shared register arbiter.
// Requesters drive req/wr_en/wr_data; the arbiter returns grant status and the stored value.
interface shared_reg_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int ID_W = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   wr_en;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   gnt;
  logic [ID_W-1:0] gnt_id;
  logic           busy;
  logic [W-1:0]   q;
  logic           q_valid;
  logic           timeout;

  modport master (
    output req, wr_en, wr_data,
    input  gnt, gnt_id, busy, q, q_valid, timeout
  );

  modport slave (
    input  req, wr_en, wr_data,
    output gnt, gnt_id, busy, q, q_valid, timeout
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// Optional macro SHARED_REG_TIMEOUT_EN bounds each grant to MAX_HOLD cycles
// and pulses timeout on a forced release; without it grants are unbounded.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests from ptr upward
// GRANT   | one requester owns the register and may write it
// RELEASE | one-cycle gap after an owner lets go (or is forced off)
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input logic        clk,
  input logic        rst,
  shared_reg_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    gnt_r, gnt_nxt;
  logic [ID_W-1:0] gnt_id_r, id_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic            busy_r, busy_nxt;
  logic [W-1:0]    q_r, q_nxt;
  logic            q_valid_r, q_valid_nxt;

  logic            own_req, own_wr;
  logic [W-1:0]    own_data;
  logic [2*N-1:0]  req_rot;
  int              off;
  int              win;
  logic            force_rel;

  // Owner's request, strobe and data selected by the registered one-hot grant
  always_comb begin
    own_req  = |(bus.req & gnt_r);
    own_wr   = |(bus.wr_en & gnt_r);
    own_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_r[i]) own_data = bus.wr_data[i*W +: W];
    end
  end

  // Rotate requests so the lowest set bit is the first requester at or above ptr
  always_comb begin
    req_rot = {bus.req, bus.req} >> ptr;
    off     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) off = i;
    end
    win = (int'(ptr) + off) % N;
  end

`ifdef SHARED_REG_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_r;

  assign force_rel = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Hold counter: zero outside GRANT, counts grant cycles; flag the forced release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= (state == GRANT) && own_req && force_rel;
      if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
      else                hold_cnt <= '0;
    end
  end

  assign bus.timeout = timeout_r;
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state and next-output logic; everything holds unless a case changes it
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt_r;
    id_nxt      = gnt_id_r;
    busy_nxt    = busy_r;
    ptr_nxt     = ptr;
    q_nxt       = q_r;
    q_valid_nxt = q_valid_r;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = GRANT;
          gnt_nxt   = N'(1) << win;
          id_nxt    = ID_W'(win);
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        // Release wins over a same-edge write strobe
        if (!own_req || force_rel) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = ID_W'((int'(gnt_id_r) + 1) % N);
        end else if (own_wr) begin
          q_nxt       = own_data;
          q_valid_nxt = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_r     <= '0;
      gnt_id_r  <= '0;
      busy_r    <= 1'b0;
      ptr       <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_r     <= gnt_nxt;
      gnt_id_r  <= id_nxt;
      busy_r    <= busy_nxt;
      ptr       <= ptr_nxt;
      q_r       <= q_nxt;
      q_valid_r <= q_valid_nxt;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.gnt_id  = gnt_id_r;
  assign bus.busy    = busy_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one W-bit storage register (a bank of async-reset D flip-flops) among N requesters. A requester raises req, receives an exclusive grant, and writes the register while it holds the grant. The block sequences ownership, muxes the owner's write data into the register, and publishes the stored value to all consumers.

Parameters:
N, 4, number of requesters (2..16)
W, 8, width of the shared register and of each write-data slice
ID_W, 2, width of gnt_id; 2**ID_W >= N is required
MAX_HOLD, 16, maximum grant length in cycles (used only when SHARED_REG_TIMEOUT_EN is defined)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
req  input  N  per-requester request level; held high for the whole ownership period
wr_en  input  N  per-requester write strobe; honoured only for the current owner
wr_data  input  N*W  concatenated write data; slice i = wr_data[i*W +: W]
gnt  output  N  registered one-hot grant; all zero when there is no owner
gnt_id  output  ID_W  index of the current owner; holds the last owner when gnt is 0
busy  output  1  high in GRANT state
q  output  W  shared register contents
q_valid  output  1  high once any write has completed since reset
timeout  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset (async, immediate, also mid-grant): state=IDLE, gnt=0, gnt_id=0, busy=0, q=0, q_valid=0, timeout=0, rr pointer ptr=0, hold counter=0.
- States: IDLE, GRANT, RELEASE. Encoding is free; all outputs are registered.
- IDLE: if req!=0, winner = first set bit of req searching from ptr upward, modulo N. Next edge: state=GRANT, gnt=onehot(winner), gnt_id=winner, busy=1. If req==0, stay in IDLE. Latency from req sampled high to gnt high is 1 cycle.
- GRANT, owner i:
  - If req[i]=1 and wr_en[i]=1 on an edge, then q <= wr_data slice i and q_valid <= 1. The write is visible on q 1 cycle after the strobe.
  - wr_en[j] for j!=i is ignored. req from other requesters is held pending with no effect.
  - If req[i]=0 on an edge, then state=RELEASE, gnt=0, busy=0, ptr=(i+1) mod N. A wr_en[i] sampled on that same edge is ignored.
- RELEASE: lasts exactly 1 cycle with no grant, then IDLE. Handover between owners is therefore: owner drops req at edge t, gnt=0 from t to t+2, new gnt at edge t+2 (IDLE arbitrates at t+1).
- Fairness: the requester that just released has the lowest priority in the next arbitration. A lone requester can be re-granted after the 2-cycle gap.
- Wrap-around: ptr=N-1 followed by a release gives ptr=0.
- q holds its value whenever no write occurs, including in IDLE and RELEASE and after a release.
- gnt is never multi-hot. gnt=0 whenever busy=0.

Optional Feature:
Macro SHARED_REG_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments every GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with req[i] still high, the next edge forces RELEASE exactly as a voluntary release, including ptr advance. timeout pulses high for that one cycle.
  - The owner must drop and re-raise req to be eligible again; re-eligibility is judged by req level in IDLE.
  - A write strobed on the forcing edge is ignored.
- Undefined: no counter logic, timeout tied to 0, grant is unbounded.

Test Plan:
- Reset/idle: assert rst mid-simulation while requester 2 owns the register with q=8'hA5 -> gnt=0, busy=0, q=0, q_valid=0 immediately, before the next clock edge.
- Single write: req[1]=1 at edge 0 -> gnt=4'b0010, gnt_id=1 after edge 0. Then wr_en[1]=1 with slice 1 = 8'h3C at edge 2 -> q=8'h3C and q_valid=1 after edge 2. req[1]=0 at edge 3 -> gnt=0 after edge 3.
- Round-robin: req=4'b1111 held, each owner releases after 2 grant cycles -> grant order 0,1,2,3,0, with a 2-cycle gnt=0 gap at each handover.
- Non-owner write: owner 0, wr_en=4'b0100 with slice 2 = 8'hFF -> q unchanged, gnt unchanged.
- Wrap and priority: ptr=3, req=4'b1001 -> requester 3 granted. After it releases, requester 0 is granted and ptr=0.
- Timeout (macro defined, MAX_HOLD=4): req[2] held for 10 cycles -> gnt[2] high exactly 4 cycles, then timeout=1 for 1 cycle. With req=4'b0110, requester 1 is granted 2 cycles later.
